port_tx: RTL and testbench
==========================

PORT_TX -- requirements
Module: port_tx

Interface
REQ-001 Parameter W_WIDTH, default 8, byte width of FIFO and port data.
REQ-002 Parameter GAP_CYCLES, default 1, idle cycles forced between packets (range 0..15).
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tx_en  input  1  permits starting a new packet.
REQ-006 fifo_empty  input  1  egress FIFO empty flag.
REQ-007 fifo_rd_en  output  1  FIFO read strobe.
REQ-008 fifo_data  input  W_WIDTH  FIFO read data, valid the cycle after an accepted read.
REQ-009 port_data  output  W_WIDTH  byte presented to the output port.
REQ-010 port_valid  output  1  port_data valid.
REQ-011 port_read  input  1  downstream accepts the byte when high with port_valid.
REQ-012 pkt_done  output  1  one-cycle pulse on acceptance of a packet's last byte.
REQ-013 pkt_cnt  output  16  completed-packet count (PORT_TX_PKT_CNT_EN only).

Function
REQ-014 A FIFO read SHALL be accepted when fifo_rd_en=1 and fifo_empty=0; data SHALL be captured from fifo_data exactly one cycle later.
REQ-015 A 2-entry skid buffer SHALL hold captured bytes; fifo_rd_en SHALL be high only when fifo_empty=0, state is not IDLE or GAP, and (buffered + in-flight - bytes accepted this cycle) < 2.
REQ-016 fifo_rd_en SHALL never be asserted while fifo_empty=1; the buffer SHALL never overflow or drop a byte.
REQ-017 port_data/port_valid SHALL present the buffer head; port_data SHALL hold stable while port_valid=1 and port_read=0.
REQ-018 Sustained throughput SHALL be one byte per cycle when FIFO non-empty and port_read=1.
REQ-019 Packet format: byte0 DA, byte1 SA, byte2 LEN=N, then N payload bytes; total N+3 bytes; N=0 legal (3-byte packet).
REQ-020 FSM states: IDLE, HDR (DA/SA), LEN, PAYLOAD, GAP.
REQ-021 IDLE->HDR when tx_en=1 and fifo_empty=0; tx_en=0 SHALL NOT abort a packet in progress.
REQ-022 HDR->LEN after SA accepted; LEN->PAYLOAD when N>0, LEN->GAP (or IDLE if GAP_CYCLES=0) when N=0, upon LEN byte acceptance.
REQ-023 An 8-bit down-counter SHALL load N on LEN acceptance and decrement per payload byte accepted; PAYLOAD exits when it transitions 1->0.
REQ-024 Reads SHALL stop at the packet's last byte; no byte of the next packet SHALL be fetched before GAP completes.
REQ-025 pkt_done SHALL pulse in the cycle the last byte is accepted; port_valid SHALL be 0 for GAP_CYCLES cycles after.
REQ-026 FIFO empty mid-packet SHALL stall (port_valid=0 once buffer drains) and resume with no byte loss or duplication.

Reset
REQ-027 On rst_n=0, immediately: state IDLE, buffer and in-flight flag cleared, fifo_rd_en=0, port_valid=0, port_data=0, pkt_done=0, counters and pkt_cnt=0.
REQ-028 Reset mid-packet SHALL discard partial packet state; a data return from a pre-reset read SHALL be ignored.

Configuration
REQ-029 Macro PORT_TX_PKT_CNT_EN defined: pkt_cnt SHALL increment on each pkt_done, wrapping 0xFFFF->0x0000.
REQ-030 Macro undefined: pkt_cnt port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 FIFO holds AA 55 02 11 22, tx_en=1, port_read=1 -> port bytes AA 55 02 11 22 on 5 consecutive valid cycles, pkt_done with 22, then 1 idle cycle.
REQ-032 Packet 01 02 00 -> 3 bytes sent, pkt_done on 00, state to GAP, no payload read.
REQ-033 port_read=0 for 4 cycles during payload -> port_data held, at most 2 bytes buffered, no fifo_rd_en with buffer full, no loss after release.
REQ-034 fifo_empty=1 after 2nd payload byte of N=4 for 3 cycles -> port_valid drops, resumes with bytes 3 and 4 in order.
REQ-035 tx_en deasserted mid-packet -> current packet completes; next packet waits until tx_en=1.
REQ-036 rst_n pulsed during payload -> all outputs zero asynchronously; with PORT_TX_PKT_CNT_EN, 3 packets then reset -> pkt_cnt 3 then 0.

Source files
------------

// File: rtl/port_tx.sv
// Packet transmit port: pulls DA/SA/LEN/payload bytes from an egress FIFO through a
// 2-entry skid buffer. Optional PORT_TX_PKT_CNT_EN adds the pkt_cnt completed-packet counter.
module port_tx #(
    parameter int unsigned W_WIDTH    = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tx_en,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic [W_WIDTH-1:0] fifo_data,
    output logic [W_WIDTH-1:0] port_data,
    output logic               port_valid,
    input  logic               port_read,
    output logic               pkt_done
`ifdef PORT_TX_PKT_CNT_EN
    ,
    output logic [15:0]        pkt_cnt
`endif
);

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_PAYLOAD,
        S_GAP
    } state_t;

    state_t state, state_nxt, end_state;

    logic [W_WIDTH-1:0] skid [2];
    logic [1:0]         skid_cnt;
    logic               rd_q;
    logic               push, accept;

    logic [1:0]         hdr_fetched;
    logic               len_pending;
    logic [7:0]         fetch_left;
    logic               fetch_ok;
    logic               in_pkt;
    logic [2:0]         occ_after;

    logic               hdr_acc;
    logic [7:0]         dcnt;
    logic [3:0]         gap_cnt;
    logic [7:0]         head_len;
    logic [7:0]         ret_len;

    assign end_state = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
    assign head_len  = 8'(skid[0]);
    assign ret_len   = 8'(fifo_data);
    assign push      = rd_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, driven by bytes accepted at the port
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (tx_en && !fifo_empty) state_nxt = S_HDR;
            end
            S_HDR: begin
                if (accept && hdr_acc) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (accept) state_nxt = (head_len != 8'd0) ? S_PAYLOAD : end_state;
            end
            S_PAYLOAD: begin
                if (accept && dcnt == 8'd1) state_nxt = end_state;
            end
            S_GAP: begin
                if (gap_cnt == 4'd0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs and read request. The LEN byte is examined on fifo_data the cycle it
    // returns so the first payload read issues without a bubble.
    always_comb begin
        port_valid = (skid_cnt != 2'd0);
        port_data  = skid[0];
        accept     = port_valid && port_read;
        in_pkt     = (state == S_HDR) || (state == S_LEN) || (state == S_PAYLOAD);
        if (hdr_fetched != 2'd3) begin
            fetch_ok = 1'b1;
        end else if (len_pending) begin
            fetch_ok = (ret_len != 8'd0);
        end else begin
            fetch_ok = (fetch_left != 8'd0);
        end
        occ_after  = {1'b0, skid_cnt} + {2'b00, rd_q} - {2'b00, accept};
        fifo_rd_en = !fifo_empty && in_pkt && fetch_ok && (occ_after < 3'd2);
        pkt_done   = accept && (((state == S_LEN) && (head_len == 8'd0)) ||
                                ((state == S_PAYLOAD) && (dcnt == 8'd1)));
    end

    // Skid buffer: entry 0 is always the head presented to the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= 1'b0;
            skid[0]  <= '0;
            skid[1]  <= '0;
            skid_cnt <= 2'd0;
        end else begin
            rd_q <= fifo_rd_en;
            case ({push, accept})
                2'b10: begin
                    if (skid_cnt == 2'd0) skid[0] <= fifo_data;
                    else                  skid[1] <= fifo_data;
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid[0]  <= skid[1];
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid[0] <= fifo_data;
                    end else begin
                        skid[0] <= skid[1];
                        skid[1] <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fetch-side framing: stop requesting once the packet's last byte has been read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_fetched <= 2'd0;
            len_pending <= 1'b0;
            fetch_left  <= 8'd0;
        end else if (!in_pkt) begin
            hdr_fetched <= 2'd0;
            len_pending <= 1'b0;
            fetch_left  <= 8'd0;
        end else begin
            if (fifo_rd_en && hdr_fetched != 2'd3) hdr_fetched <= hdr_fetched + 2'd1;
            len_pending <= fifo_rd_en && (hdr_fetched == 2'd2);
            if (len_pending) begin
                fetch_left <= ret_len - {7'd0, fifo_rd_en};
            end else if (fifo_rd_en && hdr_fetched == 2'd3) begin
                fetch_left <= fetch_left - 8'd1;
            end
        end
    end

    // Port-side framing counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_acc <= 1'b0;
            dcnt    <= 8'd0;
            gap_cnt <= 4'd0;
        end else begin
            if (state != S_HDR) begin
                hdr_acc <= 1'b0;
            end else if (accept) begin
                hdr_acc <= 1'b1;
            end

            if (state == S_LEN && accept) begin
                dcnt <= head_len;
            end else if (state == S_PAYLOAD && accept) begin
                dcnt <= dcnt - 8'd1;
            end

            if (state_nxt == S_GAP && state != S_GAP) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == S_GAP && gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

`ifdef PORT_TX_PKT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= 16'd0;
        end else if (pkt_done) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_port_tx.sv
// Randomized bench for port_tx: a FIFO model feeds packets, a byte-stream model checks the port.
module tb_port_tx;

    localparam int W = 8;
    localparam int G = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tx_en;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [W-1:0] fifo_data;
    logic [W-1:0] port_data;
    logic         port_valid;
    logic         port_read;
    logic         pkt_done;
`ifdef PORT_TX_PKT_CNT_EN
    logic [15:0]  pkt_cnt;
`endif

    always #5 clk = ~clk;

    port_tx #(.W_WIDTH(W), .GAP_CYCLES(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .port_data  (port_data),
        .port_valid (port_valid),
        .port_read  (port_read),
        .pkt_done   (pkt_done)
`ifdef PORT_TX_PKT_CNT_EN
        ,
        .pkt_cnt    (pkt_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // FIFO contents and expected port stream
    logic [7:0] fq[$];
    bit         ffirst[$];
    logic [7:0] eq[$];
    bit         elast[$];
    bit         efirst[$];

    bit         pend;
    logic [7:0] pend_data;
    int         cyc = 0;
    int         last_done = -1000;
    bit         tx_seen;
    int         rd_total, acc_total;
    bit         prev_hold;
    logic [7:0] prev_data;
    int         last_acc;
    bit         fullrate;
    int         model_cnt;

    task automatic push_byte(input logic [7:0] b, input bit first, input bit last);
        fq.push_back(b);  ffirst.push_back(first);
        eq.push_back(b);  efirst.push_back(first); elast.push_back(last);
    endtask

    task automatic push_pkt(input logic [7:0] da, input logic [7:0] sa, input int n);
        push_byte(da, 1'b1, 1'b0);
        push_byte(sa, 1'b0, 1'b0);
        push_byte(8'(n), 1'b0, n == 0);
        for (int i = 0; i < n; i++) push_byte(8'($urandom), 1'b0, i == n - 1);
    endtask

    task automatic clear_model();
        fq.delete(); ffirst.delete(); eq.delete(); elast.delete(); efirst.delete();
        pend = 0; last_done = -1000; tx_seen = 0;
        rd_total = 0; acc_total = 0; prev_hold = 0; model_cnt = 0;
    endtask

    task automatic cycle(input bit pr, input bit fe, input bit txe);
        logic [7:0] e;
        bit         l, f, acc;
        @(posedge clk); #1;
        fifo_data  = pend ? pend_data : 8'($urandom);
        pend       = 0;
        port_read  = pr;
        tx_en      = txe;
        fifo_empty = fe || (fq.size() == 0);
        @(negedge clk);
        cyc++;
`ifdef PORT_TX_PKT_CNT_EN
        check("pkt_cnt", {16'd0, pkt_cnt}, 32'(model_cnt & 32'hFFFF));
`endif
        check("rd_while_empty", 32'(fifo_rd_en & fifo_empty), 0);
        check("occupancy_le2", 32'(rd_total - acc_total <= 2), 1);
        if (prev_hold) begin
            check("hold_valid", 32'(port_valid), 1);
            check("hold_data", 32'(port_data), 32'(prev_data));
        end
        if (cyc > last_done && cyc <= last_done + G) check("gap_valid", 32'(port_valid), 0);
        acc = port_valid && port_read;
        if (acc) begin
            if (eq.size() == 0) begin
                check("extra_byte", 32'(eq.size()), 1);
            end else begin
                e = eq.pop_front(); l = elast.pop_front(); f = efirst.pop_front();
                check("data", 32'(port_data), 32'(e));
                check("done", 32'(pkt_done), 32'(l));
                if (fullrate && !f) check("rate", 32'(cyc - last_acc), 1);
                last_acc = cyc;
                acc_total++;
                if (l) begin
                    last_done = cyc; tx_seen = 0; model_cnt++;
                end
            end
        end else begin
            check("done_no_accept", 32'(pkt_done), 0);
        end
        if (fifo_rd_en && !fifo_empty) begin
            pend_data = fq.pop_front();
            f = ffirst.pop_front();
            if (f) begin
                check("fetch_after_gap", 32'(cyc > last_done + G), 1);
                check("fetch_needs_tx_en", 32'(tx_seen), 1);
            end
            pend = 1;
            rd_total++;
        end
        if (tx_en && cyc > last_done + G) tx_seen = 1;
        prev_hold = port_valid && !port_read;
        prev_data = port_data;
    endtask

    task automatic drain(input int bound, input int rp, input int ep, input int tp);
        int n = 0;
        while ((eq.size() != 0 || cyc <= last_done + G + 1) && n < bound) begin
            cycle($urandom_range(0, 99) < rp, $urandom_range(0, 99) < ep,
                  $urandom_range(0, 99) < tp);
            n++;
        end
        if (n >= bound) check("drain_timeout", 32'(eq.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(port_valid), 0);
        check({tag, "_data"},  32'(port_data), 0);
        check({tag, "_rd"},    32'(fifo_rd_en), 0);
        check({tag, "_done"},  32'(pkt_done), 0);
`ifdef PORT_TX_PKT_CNT_EN
        check({tag, "_cnt"},   {16'd0, pkt_cnt}, 0);
`endif
    endtask

    initial begin
        bit saw_drop;
        int n2;
        rst_n = 0; tx_en = 0; fifo_empty = 1; port_read = 0; fifo_data = '0;
        clear_model();
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);

        // AA 55 02 11 22 at full rate
        push_byte(8'hAA, 1, 0); push_byte(8'h55, 0, 0); push_byte(8'h02, 0, 0);
        push_byte(8'h11, 0, 0); push_byte(8'h22, 0, 1);
        fullrate = 1;
        drain(200, 100, 0, 100);
        fullrate = 0;

        // zero-length packet followed immediately by another packet
        push_pkt(8'h01, 8'h02, 0);
        push_pkt(8'h03, 8'h04, 2);
        drain(200, 100, 0, 100);

        // port_read held low mid-payload
        push_pkt(8'h10, 8'h20, 6);
        for (int i = 0; i < 14; i++) cycle(!(i >= 6 && i < 10), 0, 1);
        drain(200, 100, 0, 100);
`ifdef PORT_TX_PKT_CNT_EN
        check("pkt_cnt_after_3", {16'd0, pkt_cnt}, 4);
`endif

        // FIFO runs dry after the 2nd payload byte of an N=4 packet
        push_pkt(8'h30, 8'h40, 4);
        saw_drop = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(1, i >= 6 && i < 9, 1);
            if (i >= 6 && i < 12 && !port_valid && eq.size() != 0) saw_drop = 1;
        end
        check("stall_valid_drop", 32'(saw_drop), 1);
        drain(200, 100, 0, 100);

        // tx_en dropped mid-packet: first packet completes, second waits
        push_pkt(8'h50, 8'h60, 2);
        push_pkt(8'h70, 8'h80, 3);
        n2 = 6;
        for (int i = 0; i < 4; i++) cycle(1, 0, 1);
        for (int i = 0; i < 30; i++) cycle(1, 0, 0);
        check("tx_off_second_waits", 32'(eq.size()), 32'(n2));
        drain(200, 100, 0, 100);

        // asynchronous reset during payload
        push_pkt(8'h90, 8'hA0, 8);
        for (int i = 0; i < 9; i++) cycle(1, 0, 1);
        #2 rst_n = 0;
        #1 check_reset_outputs("mid_reset");
        clear_model();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        rst_n = 1;
        push_pkt(8'hB0, 8'hC0, 3);
        drain(200, 100, 0, 100);

        // randomized traffic
        for (int b = 0; b < 8; b++) begin
            for (int p = 0; p < 5; p++)
                push_pkt(8'($urandom), 8'($urandom), $urandom_range(0, 12));
            drain(3000, 70, 20, 80);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
